// File: rtl/prog_mem_loader.sv
// -----------------------------------------------------------------------------
// prog_mem_loader
//
// Program memory for the CPU instruction-fetch bus with a run-time byte-stream
// loader. The CPU reads instruction words combinationally; a host streams a
// download frame in through a valid/ready byte interface:
//
//   START_BYTE, data[0] .. data[2**ADDR_W-1], checksum
//
// The checksum is the modulo-2**DATA_W sum of the data bytes. While a frame is
// in flight, and after a frame whose checksum did not match, the CPU is kept
// in reset through cpu_hold.
//
// Ports:
//   clk        system clock (rising edge)
//   reset      synchronous, active-high reset; clears memory and loader state
//   mem_addr   instruction address from the CPU
//   mem_data   instruction word at mem_addr (combinational, zero latency)
//   in_data    loader byte from the host
//   in_valid   in_data is valid
//   in_ready   loader can accept a byte (always 1; the host is never stalled)
//   cpu_hold   hold request, OR-ed into the CPU reset by the top level
//   load_done  one-cycle pulse: download succeeded
//   load_err   one-cycle pulse: checksum mismatch
// -----------------------------------------------------------------------------
module prog_mem_loader #(
  parameter int                ADDR_W     = 4,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] START_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int                DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] index_reg;
  logic [DATA_W-1:0] sum_reg;
  logic              cpu_hold_reg;
  logic              load_done_reg;
  logic              load_err_reg;

  logic              accept;
  logic              write_en;
  logic [DATA_W-1:0] mem_word [DEPTH];

  // The loader never back-pressures, so every valid byte is taken.
  assign in_ready = 1'b1;
  assign accept   = in_valid && in_ready;
  assign write_en = accept && (state_reg == RECV);

  // ---------------------------------------------------------------------------
  // Storage. The memory must clear on reset and be read asynchronously, so
  // each word is its own register rather than a block RAM.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [DATA_W-1:0] word_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          word_reg <= '0;
        end else if (write_en && (index_reg == ADDR_W'(gi))) begin
          word_reg <= in_data;
        end
      end

      assign mem_word[gi] = word_reg;
    end
  endgenerate

  // A write lands on the clock edge, so the same-cycle read sees the old word.
  assign mem_data = mem_word[mem_addr];

  // ---------------------------------------------------------------------------
  // Frame state machine with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      index_reg     <= '0;
      sum_reg       <= '0;
      cpu_hold_reg  <= 1'b0;
      load_done_reg <= 1'b0;
      load_err_reg  <= 1'b0;
    end else begin
      // Result pulses last exactly one cycle.
      load_done_reg <= 1'b0;
      load_err_reg  <= 1'b0;

      if (accept) begin
        unique case (state_reg)
          IDLE: begin
            // Anything other than the header is line noise and is dropped.
            if (in_data == START_BYTE) begin
              state_reg    <= RECV;
              index_reg    <= '0;
              sum_reg      <= '0;
              cpu_hold_reg <= 1'b1;
            end
          end

          RECV: begin
            // The header value is ordinary data here; only the count ends RECV.
            sum_reg   <= sum_reg + in_data;
            index_reg <= index_reg + 1'b1;
            if (index_reg == LAST_INDEX) begin
              state_reg <= CHECK;
            end
          end

          CHECK: begin
            if (in_data == sum_reg) begin
              load_done_reg <= 1'b1;
              cpu_hold_reg  <= 1'b0;
            end else begin
              // Keep the CPU held: the image in memory is not trustworthy.
              load_err_reg <= 1'b1;
            end
            state_reg <= IDLE;
          end

          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign cpu_hold  = cpu_hold_reg;
  assign load_done = load_done_reg;
  assign load_err  = load_err_reg;

endmodule

// File: tb/tb_prog_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_mem_loader
//
// Driver issues one stimulus cycle at a time and pushes the outputs expected
// during that cycle into a queue; a separate monitor pops one entry per cycle
// on the falling edge and compares. The reference model works on whole
// frames: it collects data bytes in a queue and checks the trailing byte
// against their arithmetic sum.
// -----------------------------------------------------------------------------
module tb_prog_mem_loader;

  localparam logic [7:0] START = 8'hA5;

  logic       clk;
  logic       reset;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;

  prog_mem_loader #(
    .ADDR_W    (4),
    .DATA_W    (8),
    .START_BYTE(8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       hold;
    logic       done;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] m_mem [16];
  logic       m_hold;
  logic       m_done;
  logic       m_err;
  bit         m_in_frame;
  logic [7:0] m_frame[$];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_hold     = 1'b0;
    m_done     = 1'b0;
    m_err      = 1'b0;
    m_in_frame = 1'b0;
    m_frame.delete();
  endtask

  // Effect of one clock edge on the model.
  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    int s;
    if (r) begin
      model_reset();
      return;
    end
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!v) return;
    if (!m_in_frame) begin
      if (d == START) begin
        m_in_frame = 1'b1;
        m_frame.delete();
        m_hold = 1'b1;
      end
    end else if (m_frame.size() < 16) begin
      m_mem[m_frame.size()] = d;
      m_frame.push_back(d);
    end else begin
      s = 0;
      foreach (m_frame[i]) s += int'(m_frame[i]);
      if (d == 8'(s % 256)) begin
        m_done = 1'b1;
        m_hold = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_in_frame = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic step(input logic v, input logic [7:0] d, input logic [3:0] a,
                      input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    mem_addr = a;
    reset    = r;
    e.addr = a;
    e.data = m_mem[a];
    e.hold = m_hold;
    e.done = m_done;
    e.err  = m_err;
    exp_q.push_back(e);
    model_step(v, d, r);
  endtask

  task automatic idle_sweep();
    for (int i = 0; i < 16; i++) step(1'b0, 8'($urandom), 4'(i), 1'b0);
  endtask

  logic [7:0] frame_buf [16];

  // gap_mode: 0 = back-to-back, 1 = idle cycle after every byte, 2 = random gaps.
  // fixed_addr < 0 drives random fetch addresses.
  task automatic send_frame(input logic [7:0] chk_delta, input int gap_mode,
                            input int fixed_addr);
    logic [7:0] b;
    int         s;
    s = 0;
    for (int i = 0; i < 16; i++) s += int'(frame_buf[i]);
    for (int k = 0; k < 18; k++) begin
      if (k == 0)       b = START;
      else if (k <= 16) b = frame_buf[k-1];
      else              b = 8'(s % 256) + chk_delta;
      step(1'b1, b, (fixed_addr < 0) ? 4'($urandom) : 4'(fixed_addr), 1'b0);
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0))
        step(1'b0, 8'($urandom),
             (fixed_addr < 0) ? 4'($urandom) : 4'(fixed_addr), 1'b0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (mem_data !== e.data || cpu_hold !== e.hold || load_done !== e.done ||
          load_err !== e.err || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL cycle_check addr=%0d: got data=%h hold=%b done=%b err=%b ready=%b, expected data=%h hold=%b done=%b err=%b ready=1",
                 e.addr, mem_data, cpu_hold, load_done, load_err, in_ready,
                 e.data, e.hold, e.done, e.err);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] g;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    mem_addr = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state: every word zero, no hold, no pulses.
    idle_sweep();

    // Noise byte, then a good frame of 0..15 (checksum 8'h78).
    for (int i = 0; i < 16; i++) frame_buf[i] = 8'(i);
    step(1'b1, 8'h11, 4'h0, 1'b0);
    send_frame(8'h00, 0, -1);
    idle_sweep();

    // Same frame with checksum 8'h77, then a correct frame to release the CPU.
    send_frame(8'hFF, 0, -1);
    idle_sweep();
    send_frame(8'h00, 0, -1);
    step(1'b0, 8'h00, 4'h0, 1'b0);

    // Write/read hazard: watch address 3 while 8'hC3 is written there.
    frame_buf[3] = 8'hC3;
    send_frame(8'h00, 0, 3);
    idle_sweep();

    // Header value as data at index 5, valid toggling every other cycle.
    for (int i = 0; i < 16; i++) frame_buf[i] = 8'(i);
    frame_buf[5] = START;
    send_frame(8'h00, 1, -1);
    idle_sweep();

    // Reset after the 7th data byte, then a normal frame.
    step(1'b1, START, 4'h0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h30 + i), 4'(i), 1'b0);
    step(1'b0, 8'h00, 4'h0, 1'b1);
    idle_sweep();
    for (int i = 0; i < 16; i++) frame_buf[i] = 8'(8'hF0 ^ i);
    send_frame(8'h00, 0, -1);
    idle_sweep();

    // Randomized frames with noise, gaps and occasional bad checksums.
    for (int f = 0; f < 8; f++) begin
      for (int n = 0; n < int'($urandom_range(0, 3)); n++) begin
        g = 8'($urandom);
        if (g == START) g = g ^ 8'h01;
        step(1'b1, g, 4'($urandom), 1'b0);
      end
      for (int i = 0; i < 16; i++) frame_buf[i] = 8'($urandom);
      send_frame(($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 2, -1);
      idle_sweep();
    end

    // Let the monitor drain; anything left over counts as a miscompare.
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
